// File: rtl/inv_c_element3_r.sv
// inv_c_element3_r: bank of 3-input inverting C-elements with AND/NAND reductions.
// INVC_TOGGLE_COUNT_EN adds the 16-bit TOGGLE_CNT transition counter.
module inv_c_element3_r #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Z,
  output logic             ZALL,
  output logic             ZNAND
`ifdef INVC_TOGGLE_COUNT_EN
  ,
  output logic [15:0]      TOGGLE_CNT
`endif
);
  logic [WIDTH-1:0] s_q, s_d;
  // set on all-ones, clear on all-zeros, otherwise hold
  always_comb s_d = (A & B & C) | (s_q & (A | B | C));
  always_ff @(posedge CLK) s_q <= RESET ? '0 : s_d;
  assign Z     = ~s_q;
  assign ZALL  = &Z;
  assign ZNAND = ~ZALL;
`ifdef INVC_TOGGLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (s_d != s_q) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge CLK) cnt_q <= RESET ? '0 : cnt_d;
  assign TOGGLE_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_inv_c_element3_r.sv
// tb_inv_c_element3_r: scoreboard bench; driver queues expectations, monitor checks after each edge.
module tb_inv_c_element3_r;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a = 2'b11, b = 2'b11, c = 2'b11;
  logic [1:0] z;
  logic       zall, znand;
  logic [15:0] cnt;
  typedef struct packed {logic [1:0] z; logic [15:0] cnt;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

`ifdef INVC_TOGGLE_COUNT_EN
  inv_c_element3_r #(.WIDTH(2)) dut (.CLK(clk), .RESET(rst), .A(a), .B(b), .C(c),
    .Z(z), .ZALL(zall), .ZNAND(znand), .TOGGLE_CNT(cnt));
`else
  inv_c_element3_r #(.WIDTH(2)) dut (.CLK(clk), .RESET(rst), .A(a), .B(b), .C(c),
    .Z(z), .ZALL(zall), .ZNAND(znand));
  assign cnt = 16'd0;
`endif

  task automatic step(input logic r, input logic [1:0] ai, bi, ci, ez, input logic [15:0] ec);
    @(negedge clk);
    rst = r; a = ai; b = bi; c = ci;
    q.push_back('{z: ez, cnt: ec});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (z !== e.z) begin errors++; $display("FAIL Z: got %b want %b at %0t", z, e.z, $time); end
        checks++;
        if (zall !== &e.z) begin errors++; $display("FAIL ZALL: got %b want %b at %0t", zall, &e.z, $time); end
        checks++;
        if (znand !== ~&e.z) begin errors++; $display("FAIL ZNAND: got %b want %b at %0t", znand, ~&e.z, $time); end
`ifdef INVC_TOGGLE_COUNT_EN
        checks++;
        if (cnt !== e.cnt) begin errors++; $display("FAIL TOGGLE_CNT: got %0d want %0d at %0t", cnt, e.cnt, $time); end
`endif
      end
    end
  end

  initial begin : driver
    int n;
    step(1, 2'b11, 2'b11, 2'b11, 2'b11, 0);
    step(1, 2'b11, 2'b11, 2'b11, 2'b11, 0);
    step(0, 2'b01, 2'b01, 2'b01, 2'b10, 1);
    for (int i = 0; i < 5; i++) step(0, 2'b01, 2'b00, 2'b01, 2'b10, 1);
    step(0, 2'b00, 2'b00, 2'b00, 2'b11, 2);
    step(0, 2'b10, 2'b10, 2'b10, 2'b01, 3);
    step(1, 2'b10, 2'b10, 2'b10, 2'b11, 0);
    step(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    step(0, 2'b11, 2'b01, 2'b11, 2'b00, 1);
    step(0, 2'b00, 2'b00, 2'b00, 2'b11, 2);
    step(0, 2'b01, 2'b01, 2'b01, 2'b10, 3);
    step(0, 2'b10, 2'b10, 2'b10, 2'b01, 4);
    step(0, 2'b10, 2'b11, 2'b00, 2'b01, 4);
`ifdef INVC_TOGGLE_COUNT_EN
    step(1, 2'b00, 2'b00, 2'b00, 2'b11, 0);
    for (int i = 0; i < 65536; i++)
      if (i % 2 == 0) step(0, 2'b01, 2'b01, 2'b01, 2'b10, 16'(i + 1));
      else step(0, 2'b00, 2'b00, 2'b00, 2'b11, 16'(i + 1));
`endif
    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_c_element3_r.md
# inv_c_element3_r

Clocked model of a bank of 3-input inverting Muller C-elements with reset. It provides the acknowledge/enable primitive for PCHB-style asynchronous pipeline stages such as the router's 2-to-1 dual-rail mux. Each lane computes an inverted enable from three inputs: input-valid, select-rail and output-valid. The bank also provides AND and NAND reductions of the lane outputs, which replace discrete and2/nand2 glue when combining enables.

## Interface
- WIDTH, default 2: number of independent C-element lanes; legal range 1..32.
- CLK  input  1  rising-edge clock; all state updates occur on it.
- RESET  input  1  reset, synchronous, active-high.
- A  input  WIDTH  first input per lane; in a PCHB stage this is input valid.
- B  input  WIDTH  second input per lane; in a PCHB stage this is the select rail.
- C  input  WIDTH  third input per lane; in a PCHB stage this is output valid.
- Z  output  WIDTH  inverted C-element output per lane; acts as the enable/acknowledge.
- ZALL  output  1  AND of all Z bits; the combined enable.
- ZNAND  output  1  NAND of all Z bits; equal to ~ZALL.
- TOGGLE_CNT  output  16  transition counter. Present only when the configuration macro is defined.

## Operation
- Each lane holds one state bit S[i].
  - Z[i] = ~S[i].
- Per-lane update on each rising CLK edge while RESET=0:
  - A[i]=B[i]=C[i]=1: S[i] becomes 1, so Z[i] becomes 0.
  - A[i]=B[i]=C[i]=0: S[i] becomes 0, so Z[i] becomes 1.
  - Any mixed input pattern: S[i] holds its value.
- Lanes are fully independent. No input on one lane affects another lane.
- ZALL and ZNAND are combinational functions of the registered Z. They introduce no extra latency.
- RESET=1 at a rising edge:
  - All S clear to 0, so Z is all-ones, ZALL=1 and ZNAND=0.
  - The reset takes priority over any input pattern.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.
- Output values before the first clock edge are undefined. The bench must apply RESET for at least one edge.

## Timing
- Latency: Z reflects the sampled A/B/C exactly one rising edge after sampling.
- Hold behaviour: Z stays constant for any number of cycles while a lane's inputs remain mixed.
- Handshake usage in a PCHB stage:
  - Z[i] falls (acknowledge) only after all three inputs are high.
  - Z[i] rises (re-enable) only after all three inputs have returned low.
  - This models the four-phase return-to-zero protocol.
- Simultaneous events:
  - RESET overrides an all-ones pattern on the same edge; Z stays 1.
  - Deasserting RESET while inputs are all-ones makes Z[i] fall on the first edge with RESET=0.
- Reset mid-operation: any lane with Z=0 returns to Z=1 on the reset edge, whatever its inputs.

## Configuration
- INVC_TOGGLE_COUNT_EN defined:
  - Port TOGGLE_CNT exists.
  - It increments by 1 on each rising edge where at least one Z bit changes value.
  - It is 16-bit and wraps from 65535 to 0.
  - RESET clears it to 0 synchronously.
  - The reset edge itself does not count.
- INVC_TOGGLE_COUNT_EN undefined: the TOGGLE_CNT port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: RESET=1 for 2 edges with A=B=C=2'b11 -> Z=2'b11, ZALL=1, ZNAND=0; TOGGLE_CNT=0 when enabled.
- Set: RESET=0, A=B=C=2'b01 for 1 edge -> Z=2'b10, ZALL=0, ZNAND=1 after exactly one edge.
- Hold: from Z=2'b10, apply A=2'b01, B=2'b00, C=2'b01 for 5 edges -> Z stays 2'b10; TOGGLE_CNT does not increment.
- Release: from Z=2'b10, apply A=B=C=2'b00 -> Z=2'b11 after one edge, ZALL=1; TOGGLE_CNT incremented twice since reset.
- Lane independence: A=B=C=2'b10 with lane 0 inputs held low -> Z=2'b01; then reset while Z=2'b01 -> Z=2'b11 on the reset edge.
- Counter wrap (INVC_TOGGLE_COUNT_EN): alternate all-ones/all-zeros on lane 0 for 65536 edges -> TOGGLE_CNT returns to 0.
